mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_LSU_BURST, default 4, giving the maximum number of consecutive LSU grants while the IFU is waiting (fixed-priority mode only).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port ifu_req, input, 1, IFU fetch request, held until ifu_rsp.
REQ-005 The block SHALL have port ifu_addr, input, `RegWidth, fetch address, stable while ifu_req=1.
REQ-006 The block SHALL have port ifu_rsp, output, 1, one-cycle pulse marking ifu_rdata valid.
REQ-007 The block SHALL have port ifu_rdata, output, `ImmWidth, fetched data.
REQ-008 The block SHALL have port lsu_req, input, 1, LSU request, held until lsu_rsp.
REQ-009 The block SHALL have port lsu_we, input, 1, 1=store, 0=load.
REQ-010 The block SHALL have ports lsu_addr (`RegWidth), lsu_wdata (`RegWidth) and lsu_wdt (`WdtTypeCnt), all inputs, stable while lsu_req=1.
REQ-011 The block SHALL have ports lsu_rsp (output, 1, one-cycle completion pulse) and lsu_rdata (output, `ImmWidth, load data).
REQ-012 The block SHALL have memory-side outputs mem_raddr (`RegWidth), mem_waddr (`AddrWidth), mem_wdata (`RegWidth), mem_ren (1), mem_wen (1) and wdt_op (`WdtTypeCnt), plus input mem_rdata (`ImmWidth).

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and RESP; an owner register (IFU/LSU) SHALL be latched on IDLE->ISSUE.
REQ-014 IDLE: with any request present, the FSM SHALL latch the winner and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-015 ISSUE: the block SHALL drive exactly one memory access for one cycle and then go to RESP.
- IFU owner: mem_ren=1, mem_raddr=ifu_addr, wdt_op=`Wdt32.
- LSU load: mem_ren=1, mem_raddr=lsu_addr, wdt_op=lsu_wdt.
- LSU store: mem_wen=1, mem_waddr=lsu_addr[`AddrWidth-1:0], mem_wdata=lsu_wdata, wdt_op=lsu_wdt.
REQ-016 RESP: the block SHALL pulse the owner's rsp for one cycle, route mem_rdata to the owner's rdata (0 for a store), and return to IDLE.
REQ-017 Latency SHALL be fixed: request sampled in IDLE at cycle N, rsp at cycle N+2; the next grant is possible at N+3.
REQ-018 Outside ISSUE, mem_ren, mem_wen, all memory address/data outputs and wdt_op SHALL be 0.
REQ-019 Outside RESP, ifu_rsp, lsu_rsp, ifu_rdata and lsu_rdata SHALL be 0.
REQ-020 Fixed priority: the LSU SHALL win simultaneous requests, except that after MAX_LSU_BURST consecutive LSU grants with ifu_req=1 the IFU SHALL win.
REQ-021 The LSU burst counter SHALL clear on any IFU grant or when ifu_req=0 in IDLE, and SHALL saturate at MAX_LSU_BURST.
REQ-022 A request deasserted during ISSUE or RESP SHALL NOT abort the transaction; the access and rsp SHALL still complete.
REQ-023 The block SHALL never drive mem_ren and mem_wen both high in the same cycle.

Reset
REQ-024 With rst=0 at a posedge, the FSM SHALL go to IDLE, the owner SHALL clear to IFU, and the burst counter and last-grant flag SHALL clear.
REQ-025 While in reset, all outputs SHALL be 0.
REQ-026 Reset asserted during ISSUE or RESP SHALL drop the transaction: no rsp pulse and no memory access in the following cycle.

Configuration
REQ-027 ARB_ROUND_ROBIN_EN SHALL control the arbitration policy.
- Defined: simultaneous requests SHALL alternate owners using a last-grant flag (reset value favours the IFU first), and the burst counter and MAX_LSU_BURST SHALL be unused.
- Undefined: fixed LSU priority with the starvation guard of REQ-020/021 SHALL apply.

Verification
REQ-028 Single fetch: ifu_req=1, ifu_addr=0x80000000 -> mem_ren=1 for one cycle at N+1, ifu_rsp=1 at N+2 with ifu_rdata=mem_rdata.
REQ-029 Store then load: lsu store, addr 0x80000010, wdata 0x1122334455667788, `Wdt64 -> mem_wen pulse with matching outputs; a later load at the same addr returns 0x1122334455667788 on lsu_rdata.
REQ-030 Contention, macro undefined, MAX_LSU_BURST=4: ifu_req and lsu_req held high -> grant order L,L,L,L,I,L,L,L,L,I.
REQ-031 Contention, ARB_ROUND_ROBIN_EN defined: both requests held high from reset -> grant order I,L,I,L.
REQ-032 Reset during ISSUE of an LSU store -> mem_wen=0 in the next cycle, no lsu_rsp, FSM in IDLE.
REQ-033 lsu_req dropped in ISSUE -> lsu_rsp still pulses at N+2; mem_ren/mem_wen never both 1 at any cycle (assertion).

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU fetches and LSU loads/stores, fixed 2-cycle latency.
// Define ARB_ROUND_ROBIN_EN for alternating arbitration; default is LSU priority with an IFU starvation guard.
`ifndef RegWidth
`define RegWidth 64
`endif
`ifndef ImmWidth
`define ImmWidth 64
`endif
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif
`ifndef Wdt8
`define Wdt8 4'b0001
`endif
`ifndef Wdt16
`define Wdt16 4'b0010
`endif
`ifndef Wdt32
`define Wdt32 4'b0100
`endif
`ifndef Wdt64
`define Wdt64 4'b1000
`endif

module mem_arbiter #(
    parameter int MAX_LSU_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifu_req,
    input  logic [`RegWidth-1:0]   ifu_addr,
    output logic                   ifu_rsp,
    output logic [`ImmWidth-1:0]   ifu_rdata,
    input  logic                   lsu_req,
    input  logic                   lsu_we,
    input  logic [`RegWidth-1:0]   lsu_addr,
    input  logic [`RegWidth-1:0]   lsu_wdata,
    input  logic [`WdtTypeCnt-1:0] lsu_wdt,
    output logic                   lsu_rsp,
    output logic [`ImmWidth-1:0]   lsu_rdata,
    output logic [`RegWidth-1:0]   mem_raddr,
    output logic [`AddrWidth-1:0]  mem_waddr,
    output logic [`RegWidth-1:0]   mem_wdata,
    output logic                   mem_ren,
    output logic                   mem_wen,
    output logic [`WdtTypeCnt-1:0] wdt_op,
    input  logic [`ImmWidth-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t                 state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic                   grant_ifu;
    logic [`RegWidth-1:0]   addr_q, addr_d;
    logic [`RegWidth-1:0]   wdata_q, wdata_d;
    logic [`WdtTypeCnt-1:0] wdt_q, wdt_d;
    logic                   we_q, we_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ifu_q, last_ifu_d;
`else
    localparam int BURST_W = $clog2(MAX_LSU_BURST + 1);
    logic [BURST_W-1:0] burst_q, burst_d;
`endif

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        // A cleared last-grant flag hands the first contended slot to the IFU.
        grant_ifu = ifu_req && (!lsu_req || !last_ifu_q);
`else
        grant_ifu = ifu_req && (!lsu_req || (burst_q >= BURST_W'(MAX_LSU_BURST)));
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wdt_d     = wdt_q;
        we_d      = we_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_ifu_d = last_ifu_q;
`else
        burst_d    = burst_q;
`endif
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        wdt_op    = '0;
        ifu_rsp   = 1'b0;
        lsu_rsp   = 1'b0;
        ifu_rdata = '0;
        lsu_rdata = '0;

        case (state_q)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_d = ISSUE;
                    // Capture the request so a requester dropping out mid-transaction cannot corrupt it.
                    if (grant_ifu) begin
                        owner_d = OWN_IFU;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        wdt_d   = `Wdt32;
                        we_d    = 1'b0;
                    end else begin
                        owner_d = OWN_LSU;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wdt_d   = lsu_wdt;
                        we_d    = lsu_we;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_ifu_d = grant_ifu;
`endif
                end
`ifndef ARB_ROUND_ROBIN_EN
                if (!ifu_req || grant_ifu) begin
                    burst_d = '0;
                end else if (burst_q < BURST_W'(MAX_LSU_BURST)) begin
                    burst_d = burst_q + BURST_W'(1);
                end
`endif
            end
            ISSUE: begin
                state_d = RESP;
                if (owner_q == OWN_IFU) begin
                    mem_ren   = 1'b1;
                    mem_raddr = addr_q;
                    wdt_op    = `Wdt32;
                end else if (we_q) begin
                    mem_wen   = 1'b1;
                    mem_waddr = addr_q[`AddrWidth-1:0];
                    mem_wdata = wdata_q;
                    wdt_op    = wdt_q;
                end else begin
                    mem_ren   = 1'b1;
                    mem_raddr = addr_q;
                    wdt_op    = wdt_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_IFU) begin
                    ifu_rsp   = 1'b1;
                    ifu_rdata = mem_rdata;
                end else begin
                    lsu_rsp   = 1'b1;
                    lsu_rdata = we_q ? '0 : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs stay quiet for the whole reset cycle, including one that lands mid-transaction.
        if (!rst) begin
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            mem_raddr = '0;
            mem_waddr = '0;
            mem_wdata = '0;
            wdt_op    = '0;
            ifu_rsp   = 1'b0;
            lsu_rsp   = 1'b0;
            ifu_rdata = '0;
            lsu_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IFU;
`ifdef ARB_ROUND_ROBIN_EN
            last_ifu_q <= 1'b0;
`else
            burst_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_ifu_q <= last_ifu_d;
`else
            burst_q    <= burst_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wdt_q   <= wdt_d;
        we_q    <= we_d;
    end

endmodule
